array_insert_engine: RTL and testbench
======================================

// Module: array_insert_engine
// PURPOSE
// Inserts one value into a heap array at a given index: shifts elements [index..size-1] up by one slot,
// writes the value, then publishes size+1. Write-side counterpart of the array-counting/reading
// instructions; drives the heap memory (NArea slots per array) and the array size table.
// PARAMETERS
// MemoryElementWidth  12  width of heap elements, indices, sizes, array numbers and addresses
// NArea               3   slots per array; array a occupies heap[a*NArea .. a*NArea+NArea-1]
// NArrays             1   number of arrays; array inputs >= NArrays are a caller error (not checked)
// PORTS
// clock      in   1    single clock; all state changes on posedge
// reset      in   1    asynchronous, active-low; forces IDLE and all outputs to 0
// start      in   1    request; sampled only in IDLE
// array      in   W    array number, latched on accepted start (W = MemoryElementWidth)
// index      in   W    insertion position, latched on accepted start
// value      in   W    element to insert, latched on accepted start
// size       in   W    current size of array, latched on accepted start
// busy       out  1    high from the cycle after accept until done
// done       out  1    one-cycle completion pulse
// error      out  1    valid only with done: 1 = rejected, memory and size untouched
// mem_addr   out  W    heap address
// mem_we     out  1    heap write strobe
// mem_wdata  out  W    heap write data
// mem_rdata  in   W    heap read data, valid the cycle after mem_addr is presented with mem_we=0
// size_out   out  W    new array size
// size_we    out  1    size table write strobe for latched array
// BEHAVIOUR
// - Reset values: busy, done, error, mem_we, size_we = 0; mem_addr, mem_wdata, size_out = 0; state IDLE.
// - base = array*NArea; all address arithmetic is unsigned, modulo 2^W.
// - States: IDLE, CHECK, READ, WRITE, PUT, SIZE, DONE.
// - IDLE: start=1 latches inputs and sets i=size, then -> CHECK. start in any other state is ignored.
// - CHECK: if size >= NArea (full) or index > size -> DONE with error=1; elif i > index -> READ; else -> PUT.
// - READ: mem_addr=base+i-1, mem_we=0 -> WRITE.
// - WRITE: mem_addr=base+i, mem_wdata=mem_rdata, mem_we=1; i=i-1; -> READ if i-1 > index, else -> PUT.
// - PUT: mem_addr=base+index, mem_wdata=value, mem_we=1 -> SIZE.
// - SIZE: size_out=size+1, size_we=1 -> DONE.
// - DONE: done=1 (error as decided), busy=0 -> IDLE. A start in DONE is ignored; a start in the
//   following IDLE cycle is accepted (back-to-back throughput = one op per latency+1).
// - Latency: k = size-index shifts; done is high in cycle 2k+4 after the accepting edge
//   (edge 0); the error path gives done in cycle 2. mem_we and size_we are never high together;
//   mem_we is high for exactly k+1 cycles per successful op, and size_we is high for exactly 1 cycle.
// - Shifts proceed top-down, so no element is overwritten before it has been read.
// - Reset mid-operation: immediate return to IDLE, outputs 0; heap may be partially shifted
//   (no rollback); size table is unchanged unless SIZE already completed.
// - index == size (append): no shift; only PUT and SIZE.
// TESTING
// 1 array0 size=2 heap[10,30,x], start index=1 value=20 -> writes heap[2]=30 then heap[1]=20;
//   size_out=3 size_we pulse; done in cycle 6, error=0; heap=[10,20,30]
// 2 size=1 heap[10], index=1 value=40 -> single write heap[1]=40; size_out=2; done in cycle 4
// 3 size=2 heap[20,30], index=0 value=10 -> heap=[10,20,30], 3 writes; done in cycle 8
// 4 size=3 (full), any index -> done+error in cycle 2; no mem_we or size_we pulse
// 5 size=1, index=2 -> done+error in cycle 2, no writes; then start pulsed during busy of a valid
//   op -> ignored, only one done
// 6 reset low during READ of test 3 -> all outputs 0 the same cycle, IDLE; a new start after
//   reset release completes normally

Source files
------------

// File: rtl/array_insert_engine_if.sv
// Bundle of request, status, heap-memory and size-table signals for
// array_insert_engine.
//   master : the caller/environment (drives the request, supplies mem_rdata)
//   slave  : the engine (drives status, heap writes and the size table)
interface array_insert_engine_if #(
  parameter int unsigned W = 12
) ();
  logic         start;
  logic [W-1:0] array;
  logic [W-1:0] index;
  logic [W-1:0] value;
  logic [W-1:0] size;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] mem_addr;
  logic         mem_we;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic [W-1:0] size_out;
  logic         size_we;

  modport master (
    output start, array, index, value, size, mem_rdata,
    input  busy, done, error, mem_addr, mem_we, mem_wdata, size_out, size_we
  );

  modport slave (
    input  start, array, index, value, size, mem_rdata,
    output busy, done, error, mem_addr, mem_we, mem_wdata, size_out, size_we
  );
endinterface

// File: rtl/array_insert_engine.sv
// array_insert_engine
// Inserts one value into a heap-resident array at a given index. Elements
// [index..size-1] are moved up one slot top-down (read, then write one slot
// higher), the value is written at index, and size+1 is published to the
// array size table.
// Ports:
//   clock   : single clock, all state changes on posedge
//   reset   : asynchronous, active-low; forces IDLE and all outputs to 0
//   bus     : slave side of array_insert_engine_if
//             start/array/index/value/size : request, latched on accept in IDLE
//             busy/done/error              : status (error valid only with done)
//             mem_addr/mem_we/mem_wdata    : heap access, mem_rdata arrives
//                                            the cycle after a read address
//             size_out/size_we             : size table update for the array
module array_insert_engine #(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NArea              = 3,
  parameter int unsigned NArrays            = 1
) (
  input logic                 clock,
  input logic                 reset,
  array_insert_engine_if.slave bus
);
  localparam int unsigned W     = MemoryElementWidth;
  localparam logic [W-1:0] AreaW = W'(NArea);
  localparam logic [W-1:0] One   = W'(1);

  if (NArea < 1 || NArrays < 1) begin : g_param_check
    $error("array_insert_engine: NArea and NArrays must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WRITE,
    S_PUT,
    S_SIZE,
    S_DONE
  } state_t;

  state_t       state_q;
  logic [W-1:0] base_q;
  logic [W-1:0] index_q;
  logic [W-1:0] value_q;
  logic [W-1:0] size_q;
  logic [W-1:0] i_q;
  logic         busy_q;
  logic         done_q;
  logic         error_q;
  logic         mem_we_q;
  logic         size_we_q;
  logic [W-1:0] mem_addr_q;
  logic [W-1:0] wdata_q;
  logic [W-1:0] size_out_q;
  logic [W-1:0] i_dec;

  always_comb begin
    i_dec = i_q - One;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      index_q    <= '0;
      value_q    <= '0;
      size_q     <= '0;
      i_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      size_we_q  <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      size_out_q <= '0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      mem_we_q  <= 1'b0;
      size_we_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            base_q  <= bus.array * AreaW;
            index_q <= bus.index;
            value_q <= bus.value;
            size_q  <= bus.size;
            i_q     <= bus.size;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (size_q >= AreaW || index_q > size_q) begin
            done_q  <= 1'b1;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (i_q > index_q) begin
            mem_addr_q <= base_q + i_dec;
            state_q    <= S_READ;
          end else begin
            mem_addr_q <= base_q + index_q;
            wdata_q    <= value_q;
            mem_we_q   <= 1'b1;
            state_q    <= S_PUT;
          end
        end

        S_READ: begin
          mem_addr_q <= base_q + i_q;
          mem_we_q   <= 1'b1;
          state_q    <= S_WRITE;
        end

        S_WRITE: begin
          i_q <= i_dec;
          if (i_dec > index_q) begin
            mem_addr_q <= base_q + i_dec - One;
            state_q    <= S_READ;
          end else begin
            mem_addr_q <= base_q + index_q;
            wdata_q    <= value_q;
            mem_we_q   <= 1'b1;
            state_q    <= S_PUT;
          end
        end

        S_PUT: begin
          size_out_q <= size_q + One;
          size_we_q  <= 1'b1;
          state_q    <= S_SIZE;
        end

        S_SIZE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.size_we  = size_we_q;
  assign bus.size_out = size_out_q;
  // The element being moved only arrives from the heap during WRITE itself,
  // so write data bypasses the register in that state.
  assign bus.mem_wdata = (state_q == S_WRITE) ? bus.mem_rdata : wdata_q;
endmodule

// File: tb/tb_array_insert_engine.sv
module tb_array_insert_engine;
  localparam int W     = 12;
  localparam int NAREA = 3;
  localparam int NARR  = 2;
  localparam int HS    = NAREA * NARR;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  array_insert_engine_if #(.W(W)) ifc ();

  array_insert_engine #(
    .MemoryElementWidth(W),
    .NArea(NAREA),
    .NArrays(NARR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(ifc.slave)
  );

  logic [W-1:0] heap [0:4095];
  logic [W-1:0] ref_heap [0:HS-1];
  logic         pre_we = 1'b0;
  logic [W-1:0] pre_addr = '0;
  logic [W-1:0] pre_data = '0;

  int unsigned we_total = 0;
  int unsigned swe_total = 0;
  int unsigned done_total = 0;
  int unsigned overlap_total = 0;
  int checks = 0;
  int passes = 0;

  // Heap memory: registered read, data valid the cycle after the address.
  always @(posedge clock) begin
    if (pre_we) heap[pre_addr] <= pre_data;
    else if (ifc.mem_we) heap[ifc.mem_addr] <= ifc.mem_wdata;
    if (!ifc.mem_we) ifc.mem_rdata <= heap[ifc.mem_addr];
  end

  always @(negedge clock) begin
    if (ifc.mem_we === 1'b1) we_total++;
    if (ifc.size_we === 1'b1) swe_total++;
    if (ifc.done === 1'b1) done_total++;
    if (ifc.mem_we === 1'b1 && ifc.size_we === 1'b1) overlap_total++;
  end

  task automatic load_heap();
    for (int a = 0; a < HS; a++) begin
      pre_we = 1'b1;
      pre_addr = W'(a);
      pre_data = ref_heap[a];
      @(posedge clock); #1;
    end
    pre_we = 1'b0;
  endtask

  task automatic randomize_ref();
    for (int a = 0; a < HS; a++) ref_heap[a] = W'($urandom_range(0, 4095));
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({ifc.busy, ifc.done, ifc.error, ifc.mem_we, ifc.size_we} !== 5'b0) begin
      $display("FAIL %s_flags: got %b expected 00000", tag,
               {ifc.busy, ifc.done, ifc.error, ifc.mem_we, ifc.size_we});
    end else passes++;
    checks++;
    if ({ifc.mem_addr, ifc.mem_wdata} !== '0) begin
      $display("FAIL %s_membus: got addr=%0d wdata=%0d expected 0/0", tag, ifc.mem_addr, ifc.mem_wdata);
    end else passes++;
    checks++;
    if (ifc.size_out !== '0) begin
      $display("FAIL %s_size_out: got %0d expected 0", tag, ifc.size_out);
    end else passes++;
  endtask

  // One insert operation, checked against a queue-based model of the array.
  // hold: keep start high through the whole op (it must be ignored while busy)
  // from_done: raise start during the previous op's done cycle
  task automatic run_op(input int arr, input int idx, input int val, input int sz,
                        input bit hold, input bit from_done, input string tag);
    logic [W-1:0] q[$];
    bit exp_err;
    int k, exp_lat, base, cyc;
    int unsigned we0, swe0, done0, ov0;

    base = arr * NAREA;
    exp_err = (sz >= NAREA) || (idx > sz);
    k = exp_err ? 0 : sz - idx;
    exp_lat = exp_err ? 2 : 2 * k + 4;
    if (!exp_err) begin
      q = {};
      for (int j = 0; j < sz; j++) q.push_back(ref_heap[base + j]);
      q.insert(idx, W'(val));
      for (int j = 0; j <= sz; j++) ref_heap[base + j] = q[j];
    end

    if (!from_done) begin
      @(posedge clock); #1;
    end
    we0 = we_total; swe0 = swe_total; done0 = done_total; ov0 = overlap_total;
    ifc.start = 1'b1;
    ifc.array = W'(arr);
    ifc.index = W'(idx);
    ifc.value = W'(val);
    ifc.size  = W'(sz);
    if (from_done) begin
      @(posedge clock); #1;
      checks++;
      if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
        $display("FAIL %s_ignored_in_done: got busy=%b done=%b expected 0/0", tag, ifc.busy, ifc.done);
      end else passes++;
    end
    @(posedge clock); #1;
    if (!hold) ifc.start = 1'b0;
    ifc.array = W'($urandom_range(0, 4095));
    ifc.index = W'($urandom_range(0, 4095));
    ifc.value = W'($urandom_range(0, 4095));
    ifc.size  = W'($urandom_range(0, 4095));
    cyc = 1;
    checks++;
    if (ifc.busy !== 1'b1) begin
      $display("FAIL %s_busy_c1: got %b expected 1", tag, ifc.busy);
    end else passes++;
    while (ifc.done !== 1'b1 && cyc < 64) begin
      @(posedge clock); #1;
      cyc++;
    end
    checks++;
    if (ifc.done !== 1'b1 || cyc != exp_lat) begin
      $display("FAIL %s_latency: got done=%b at cycle %0d expected cycle %0d", tag, ifc.done, cyc, exp_lat);
    end else passes++;
    checks++;
    if (ifc.error !== exp_err || ifc.busy !== 1'b0) begin
      $display("FAIL %s_error: got error=%b busy=%b expected %b/0", tag, ifc.error, ifc.busy, exp_err);
    end else passes++;
    checks++;
    if (we_total - we0 != (exp_err ? 0 : k + 1)) begin
      $display("FAIL %s_we_count: got %0d expected %0d", tag, we_total - we0, exp_err ? 0 : k + 1);
    end else passes++;
    checks++;
    if (swe_total - swe0 != (exp_err ? 0 : 1) || overlap_total != ov0) begin
      $display("FAIL %s_size_we: got count=%0d overlap=%0d expected %0d/0", tag,
               swe_total - swe0, overlap_total - ov0, exp_err ? 0 : 1);
    end else passes++;
    if (!exp_err) begin
      checks++;
      if (ifc.size_out !== W'(sz + 1)) begin
        $display("FAIL %s_size_out: got %0d expected %0d", tag, ifc.size_out, sz + 1);
      end else passes++;
    end
    if (hold) begin
      ifc.start = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      checks++;
      if (done_total - done0 != 1) begin
        $display("FAIL %s_single_done: got %0d done pulses expected 1", tag, done_total - done0);
      end else passes++;
    end
    for (int a = 0; a < HS; a++) begin
      checks++;
      if (heap[a] !== ref_heap[a]) begin
        $display("FAIL %s_heap[%0d]: got %0d expected %0d", tag, a, heap[a], ref_heap[a]);
      end else passes++;
    end
  endtask

  task automatic test_reset();
    ifc.start = 1'b0; ifc.array = '0; ifc.index = '0; ifc.value = '0; ifc.size = '0;
    reset = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    check_outputs_zero("reset");
    reset = 1'b1;
    @(posedge clock); #1;
    check_outputs_zero("post_reset");
  endtask

  task automatic test_directed();
    randomize_ref();
    ref_heap[0] = 12'd10; ref_heap[1] = 12'd30;
    load_heap();
    run_op(0, 1, 20, 2, 1'b0, 1'b0, "t1_mid");
    randomize_ref();
    ref_heap[0] = 12'd10;
    load_heap();
    run_op(0, 1, 40, 1, 1'b0, 1'b0, "t2_append");
    randomize_ref();
    ref_heap[0] = 12'd20; ref_heap[1] = 12'd30;
    load_heap();
    run_op(0, 0, 10, 2, 1'b0, 1'b0, "t3_front");
    run_op(0, 1, 99, 3, 1'b0, 1'b0, "t4_full");
  endtask

  task automatic test_error_and_ignore();
    randomize_ref();
    load_heap();
    run_op(0, 2, 55, 1, 1'b0, 1'b0, "t5_badidx");
    run_op(1, 0, 321, 2, 1'b1, 1'b0, "t5_hold");
  endtask

  task automatic test_back_to_back();
    randomize_ref();
    load_heap();
    run_op(0, 0, 7, 1, 1'b0, 1'b0, "b2b_a");
    run_op(1, 0, 77, 0, 1'b0, 1'b1, "b2b_b");
    run_op(1, 0, 78, 1, 1'b0, 1'b1, "b2b_c");
  endtask

  task automatic test_reset_mid();
    int unsigned we0, swe0;
    randomize_ref();
    ref_heap[0] = 12'd20; ref_heap[1] = 12'd30;
    load_heap();
    @(posedge clock); #1;
    we0 = we_total; swe0 = swe_total;
    ifc.start = 1'b1; ifc.array = '0; ifc.index = '0; ifc.value = 12'd10; ifc.size = 12'd2;
    @(posedge clock); #1;
    ifc.start = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (ifc.mem_addr !== 12'd1 || ifc.mem_we !== 1'b0 || ifc.busy !== 1'b1) begin
      $display("FAIL mid_read: got addr=%0d we=%b busy=%b expected 1/0/1", ifc.mem_addr, ifc.mem_we, ifc.busy);
    end else passes++;
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    checks++;
    if (we_total != we0 || swe_total != swe0 || ifc.busy !== 1'b0) begin
      $display("FAIL mid_no_writes: got we=%0d size_we=%0d busy=%b expected 0/0/0",
               we_total - we0, swe_total - swe0, ifc.busy);
    end else passes++;
    run_op(0, 0, 10, 2, 1'b0, 1'b0, "mid_restart");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      randomize_ref();
      load_heap();
      run_op($urandom_range(0, NARR - 1), $urandom_range(0, 3), $urandom_range(0, 4095),
             $urandom_range(0, 3), bit'($urandom_range(0, 1)), 1'b0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_error_and_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
